// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the async-FIFO read-side packer.
package fifo_pkg;

  localparam int DWIDTH_DEF = 8;
  localparam int PACK_DEF   = 4;
  localparam int PACK_MAX   = 16;

  function automatic int cnt_width(input int pack);
    return $clog2(pack + 1);
  endfunction

  localparam int CNTW = cnt_width(PACK_DEF);

  // Low `cnt` bits set; callers slice the result down to PACK bits.
  function automatic logic [PACK_MAX-1:0] keep_mask(input int unsigned cnt);
    logic [PACK_MAX:0] one;
    logic [PACK_MAX:0] m;
    one    = '0;
    one[0] = 1'b1;
    m      = (one << cnt) - one;
    return m[PACK_MAX-1:0];
  endfunction

endpackage

// File: rtl/fifo_rd_out_reg.sv
// Valid/ready holding register: loads a word, holds it while stalled, clears once accepted.
module fifo_rd_out_reg #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic [W-1:0] data_o,
  output logic         valid_o
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  // A load in the accept cycle reloads and keeps valid high (back-to-back words).
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fifo_rd_packer.sv
// Drains the FIFO and packs PACK entries per output word on a valid/ready port.
// Define PACKER_FLUSH_EN to add a flush input that emits partial words with out_keep.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter  int DWIDTH = DWIDTH_DEF,
  parameter  int PACK   = PACK_DEF,
  localparam int OWIDTH = PACK * DWIDTH
) (
  input  logic              rclk,
  input  logic              reset,
  input  logic              empty,
  output logic              pop,
  input  logic [DWIDTH-1:0] rdata,
  output logic [OWIDTH-1:0] out_data,
  output logic              out_valid,
`ifdef PACKER_FLUSH_EN
  input  logic              flush,
  output logic [PACK-1:0]   out_keep,
`endif
  input  logic              out_ready
);

  localparam int            CW   = cnt_width(PACK);
  localparam logic [CW-1:0] LAST = CW'(PACK - 1);
`ifdef PACKER_FLUSH_EN
  localparam int            PW   = OWIDTH + PACK;
`else
  localparam int            PW   = OWIDTH;
`endif

  logic [CW-1:0]     cnt_q, cnt_d, eff;
  logic              inflight_q;
  logic [OWIDTH-1:0] asm_q, asm_d, asm_wr;
  logic              load;
  logic [PW-1:0]     load_payload, out_payload;
  logic              pop_hold;

`ifdef PACKER_FLUSH_EN
  logic                flush_pend_q, flush_pend_d;
  logic [PACK_MAX-1:0] mask_full;

  assign mask_full = keep_mask(32'(cnt_q));
  assign pop_hold  = flush_pend_q || ((eff == LAST) && out_valid);
`else
  assign pop_hold  = (eff == LAST) && out_valid;
`endif

  assign eff = cnt_q + CW'(inflight_q);
  // Never request the completing entry while the output register is still occupied.
  assign pop = !reset && !empty && !pop_hold;

  always_comb begin
    // NOTE: every signal driven here is defaulted first so no path can infer a latch.
    cnt_d        = cnt_q;
    asm_d        = asm_q;
    asm_wr       = asm_q;
    load         = 1'b0;
    load_payload = '0;
`ifdef PACKER_FLUSH_EN
    flush_pend_d = flush_pend_q | flush;
`endif
    for (int i = 0; i < PACK; i++) begin
      if (cnt_q == CW'(i)) asm_wr[i*DWIDTH +: DWIDTH] = rdata;
    end

    if (inflight_q) begin
      if (cnt_q == LAST) begin
        load  = 1'b1;
        cnt_d = '0;
        asm_d = '0;
`ifdef PACKER_FLUSH_EN
        load_payload = {{PACK{1'b1}}, asm_wr};
`else
        load_payload = asm_wr;
`endif
      end else begin
        cnt_d = cnt_q + CW'(1);
        asm_d = asm_wr;
      end
    end
`ifdef PACKER_FLUSH_EN
    else if (flush_pend_q && !out_valid) begin
      flush_pend_d = flush;
      if (cnt_q != '0) begin
        load         = 1'b1;
        load_payload = {mask_full[PACK-1:0], asm_q};
        cnt_d        = '0;
        asm_d        = '0;
      end
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge rclk) begin
    if (reset) begin
      // NOTE: the assembly data register is cleared too, so no stale entry leaks into a later word.
      cnt_q        <= '0;
      inflight_q   <= 1'b0;
      asm_q        <= '0;
`ifdef PACKER_FLUSH_EN
      flush_pend_q <= 1'b0;
`endif
    end else begin
      cnt_q        <= cnt_d;
      inflight_q   <= pop;
      asm_q        <= asm_d;
`ifdef PACKER_FLUSH_EN
      flush_pend_q <= flush_pend_d;
`endif
    end
  end

  fifo_rd_out_reg #(.W(PW)) u_out_reg (
    .clk_i   (rclk),
    .reset_i (reset),
    .load_i  (load),
    .data_i  (load_payload),
    .ready_i (out_ready),
    .data_o  (out_payload),
    .valid_o (out_valid)
  );

  assign out_data = out_payload[OWIDTH-1:0];
`ifdef PACKER_FLUSH_EN
  assign out_keep = out_payload[PW-1 -: PACK];
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a registered-read FIFO model (DWIDTH=8, PACK=4).
`timescale 1ns/1ps
module tb_fifo_rd_packer;

  localparam int DW = 8;
  localparam int PK = 4;
  localparam int OW = DW * PK;

  logic          rclk      = 1'b0;
  logic          reset     = 1'b1;
  logic          empty;
  logic          pop;
  logic [DW-1:0] rdata     = '0;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
`ifdef PACKER_FLUSH_EN
  logic          flush     = 1'b0;
  logic [PK-1:0] out_keep;
  logic [PK-1:0] last_keep = '0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // FIFO model: data is presented the cycle after a pop.
  logic [7:0] mem [0:255];
  int wr_ptr    = 0;
  int rd_ptr    = 0;
  int pop_total = 0;
  int bad_pops  = 0;

  always #5 rclk = ~rclk;

  assign empty = (rd_ptr == wr_ptr);

  always @(posedge rclk) begin
    if (pop) begin
      if (empty) bad_pops <= bad_pops + 1;
      rdata     <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
      pop_total <= pop_total + 1;
    end
  end

  fifo_rd_packer #(.DWIDTH(DW), .PACK(PK)) dut (
    .rclk      (rclk),
    .reset     (reset),
    .empty     (empty),
    .pop       (pop),
    .rdata     (rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
`ifdef PACKER_FLUSH_EN
    .flush     (flush),
    .out_keep  (out_keep),
`endif
    .out_ready (out_ready)
  );

  task automatic push(input logic [7:0] v);
    mem[wr_ptr] = v;
    wr_ptr++;
  endtask

  // Returns at a falling edge once a valid word has been seen (and accepted if out_ready was high).
  task automatic wait_word(output logic [OW-1:0] w, output bit ok);
    ok = 1'b0;
    w  = '0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (out_valid) begin
        ok = 1'b1;
        w  = out_data;
`ifdef PACKER_FLUSH_EN
        last_keep = out_keep;
`endif
      end
      @(negedge rclk);
      if (ok) break;
    end
  endtask

  task automatic test_reset();
    logic [OW-1:0] w;
    bit ok;
    reset = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(8'hA1 + 8'(i));
    @(negedge rclk);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (pop !== 1'b0) begin n_fail++; $display("FAIL reset_pop: got %b expected 0", pop); end
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
      n_checks++;
      if (out_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", out_data); end
      @(negedge rclk);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (pop !== 1'b1) begin n_fail++; $display("FAIL reset_first_pop: got %b expected 1", pop); end
    wait_word(w, ok);
    n_checks++;
    if (!ok || w !== 32'hA4A3A2A1) begin
      n_fail++; $display("FAIL reset_first_word: got %h (seen=%0d) expected a4a3a2a1", w, ok);
    end
  endtask

  task automatic test_streaming();
    int pop_at [8];
    int valid_at [2];
    logic [OW-1:0] words [2];
    int np, nv;
    np = 0; nv = 0;
    for (int i = 0; i < 8; i++) pop_at[i] = -100;
    valid_at[0] = -100; valid_at[1] = -100;
    words[0] = '0; words[1] = '0;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(8'(i));
    for (int c = 0; c < 14; c++) begin
      #1;
      if (pop && np < 8) begin pop_at[np] = c; np++; end
      if (out_valid) begin
        if (nv < 2) begin valid_at[nv] = c; words[nv] = out_data; end
        nv++;
      end
      @(negedge rclk);
    end
    n_checks++;
    if (np != 8 || pop_at[7] - pop_at[0] != 7) begin
      n_fail++; $display("FAIL stream_pops: got %0d pops spanning %0d cycles expected 8 over 7", np, pop_at[7] - pop_at[0]);
    end
    n_checks++;
    if (nv != 2) begin n_fail++; $display("FAIL stream_valid_cycles: got %0d expected 2", nv); end
    n_checks++;
    if (words[0] !== 32'h04030201) begin n_fail++; $display("FAIL stream_word0: got %h expected 04030201", words[0]); end
    n_checks++;
    if (words[1] !== 32'h08070605) begin n_fail++; $display("FAIL stream_word1: got %h expected 08070605", words[1]); end
    n_checks++;
    if (valid_at[0] - pop_at[3] != 2) begin
      n_fail++; $display("FAIL stream_latency: got %0d expected 2", valid_at[0] - pop_at[3]);
    end
  endtask

  task automatic test_backpressure();
    logic [OW-1:0] w;
    logic [OW-1:0] exp_words [3];
    bit ok, stable;
    int base;
    exp_words[0] = 32'h04030201;
    exp_words[1] = 32'h14131211;
    exp_words[2] = 32'h18171615;
    out_ready = 1'b0;
    base = pop_total;
    for (int i = 1; i <= 4; i++) push(8'(i));
    for (int i = 0; i < 8; i++) push(8'h11 + 8'(i));
    wait_word(w, ok);
    n_checks++;
    if (!ok || w !== 32'h04030201) begin n_fail++; $display("FAIL bp_first: got %h expected 04030201", w); end
    stable = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (out_valid !== 1'b1 || out_data !== 32'h04030201) stable = 1'b0;
      @(negedge rclk);
    end
    n_checks++;
    if (!stable) begin n_fail++; $display("FAIL bp_hold: got %h valid=%b expected 04030201 held", out_data, out_valid); end
    #1;
    n_checks++;
    if (pop_total - base != 7) begin n_fail++; $display("FAIL bp_pop_count: got %0d expected 7", pop_total - base); end
    n_checks++;
    if (pop !== 1'b0) begin n_fail++; $display("FAIL bp_pop_stalled: got %b expected 0", pop); end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_word(w, ok);
      n_checks++;
      if (!ok || w !== exp_words[k]) begin
        n_fail++; $display("FAIL bp_word%0d: got %h expected %h", k, w, exp_words[k]);
      end
    end
    n_checks++;
    if (pop_total - base != 12) begin n_fail++; $display("FAIL bp_total_pops: got %0d expected 12", pop_total - base); end
  endtask

  task automatic test_empty_boundary();
    logic [OW-1:0] w;
    bit ok;
    int base, nv, pe;
    out_ready = 1'b1;
    base = pop_total;
    nv = 0; pe = 0;
    push(8'hAA); push(8'hBB); push(8'hCC);
    for (int c = 0; c < 10; c++) begin
      #1;
      if (out_valid) nv++;
      if (pop && empty) pe++;
      @(negedge rclk);
    end
    n_checks++;
    if (nv != 0) begin n_fail++; $display("FAIL empty_no_output: got %0d valid cycles expected 0", nv); end
    n_checks++;
    if (pe != 0) begin n_fail++; $display("FAIL empty_pop: got %0d pops while empty expected 0", pe); end
    n_checks++;
    if (pop_total - base != 3) begin n_fail++; $display("FAIL empty_pop_count: got %0d expected 3", pop_total - base); end
    #1;
    push(8'hDD);
    wait_word(w, ok);
    n_checks++;
    if (!ok || w !== 32'hDDCCBBAA) begin n_fail++; $display("FAIL empty_resume: got %h expected ddccbbaa", w); end
  endtask

  task automatic test_reset_mid_word();
    logic [OW-1:0] w;
    bit ok, found;
    int base;
    out_ready = 1'b1;
    base = pop_total;
    found = 1'b0;
    push(8'h31); push(8'h32); push(8'h33);
    for (int c = 0; c < 10; c++) begin
      #1;
      if (pop_total - base == 3) begin found = 1'b1; break; end
      @(negedge rclk);
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL midrst_pops: got %0d pops expected 3", pop_total - base); end
    reset = 1'b1;
    @(negedge rclk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) push(8'h21 + 8'(i));
    wait_word(w, ok);
    n_checks++;
    if (!ok || w !== 32'h24232221) begin n_fail++; $display("FAIL midrst_word: got %h expected 24232221", w); end
  endtask

`ifdef PACKER_FLUSH_EN
  task automatic test_flush();
    logic [OW-1:0] w;
    bit ok;
    int nv;
    out_ready = 1'b1;
    push(8'h55); push(8'h66);
    repeat (5) @(negedge rclk);
    flush = 1'b1;
    @(negedge rclk);
    flush = 1'b0;
    wait_word(w, ok);
    n_checks++;
    if (!ok || w[15:0] !== 16'h6655) begin n_fail++; $display("FAIL flush_data: got %h expected 6655", w[15:0]); end
    n_checks++;
    if (last_keep !== 4'b0011) begin n_fail++; $display("FAIL flush_keep: got %b expected 0011", last_keep); end
    nv = 0;
    flush = 1'b1;
    @(negedge rclk);
    flush = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (out_valid) nv++;
      @(negedge rclk);
    end
    n_checks++;
    if (nv != 0) begin n_fail++; $display("FAIL flush_empty: got %0d valid cycles expected 0", nv); end
    for (int i = 0; i < 4; i++) push(8'h71 + 8'(i));
    wait_word(w, ok);
    n_checks++;
    if (!ok || w !== 32'h74737271) begin n_fail++; $display("FAIL flush_after: got %h expected 74737271", w); end
    n_checks++;
    if (last_keep !== 4'b1111) begin n_fail++; $display("FAIL flush_full_keep: got %b expected 1111", last_keep); end
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_empty_boundary();
    test_reset_mid_word();
`ifdef PACKER_FLUSH_EN
    test_flush();
`endif
    n_checks++;
    if (bad_pops != 0) begin n_fail++; $display("FAIL pop_when_empty: got %0d expected 0", bad_pops); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Read-side consumer of the async FIFO; lives entirely in the read clock domain.
- Drains DWIDTH-bit entries through the FIFO's pop/empty/rdata interface and packs PACK consecutive entries into one word.
- Presents the packed word on a valid/ready output towards the downstream datapath.
- Absorbs the FIFO's registered-read latency and applies backpressure by withholding pop.

Parameters:
- DWIDTH, 8, FIFO entry width in bits; must match the FIFO's DWIDTH.
- PACK, 4, entries per output word; legal range 2..16.
- OWIDTH, PACK*DWIDTH, output word width; derived, never overridden.

Ports:
- rclk  input  1  read-domain clock; all state is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- empty  input  1  FIFO empty flag, already synchronous to rclk.
- pop  output  1  FIFO read request.
- rdata  input  DWIDTH  FIFO read data; valid the cycle after a cycle with pop=1.
- out_data  output  OWIDTH  packed word; entry 0 (oldest) in bits [DWIDTH-1:0].
- out_valid  output  1  out_data holds a word.
- out_ready  input  1  downstream accepts the word when out_valid && out_ready.

Behaviour:
- Reset (reset=1 at an rclk edge) clears the following to 0: cnt, inflight, asm register, out_valid, out_data and pop.
  - This takes priority over every other event.
  - A byte in flight when reset asserts is discarded.
  - After reset, the first word is built from the next popped entry.
- State:
  - cnt: entries held in the assembly register, 0..PACK-1.
  - inflight: 1 if pop was 1 in the previous cycle.
  - eff = cnt + inflight, range 0..PACK.
- Pop rule (combinational, registered-free):
  - pop = !empty && !(eff == PACK-1 && out_valid).
  - The completing entry is never requested while the output register is occupied.
  - pop never asserts when empty=1.
- Arrival: when inflight=1, rdata is written into slot cnt of asm and cnt increments.
  - If the arriving entry is slot PACK-1, the full word moves to out_data, out_valid is set next edge, and cnt returns to 0.
  - The output register is guaranteed free at that point by the pop rule.
- Output handshake:
  - out_valid stays high and out_data stays stable until the cycle where out_ready=1.
  - out_valid clears on that edge unless a new word completes in the same cycle. In that case out_data reloads and out_valid stays 1 (back-to-back words).
- Latency:
  - Last entry's pop to out_valid is 2 cycles.
  - With empty=0 and out_ready=1 held, throughput is one pop per cycle with no bubbles.
- Wrap-around: cnt wraps PACK-1 -> 0 only on completion; partial words are held indefinitely (base build).
- empty rising mid-word: pops stop, the partial word is retained, and packing resumes when empty falls.

Optional Feature:
- Macro PACKER_FLUSH_EN.
- Defined:
  - Extra ports: flush input 1, and out_keep output PACK (one bit per entry, bit i = entry i valid).
  - A one-cycle flush pulse sets flush_pend. While flush_pend=1, pop is forced 0.
  - Once inflight=0 and out_valid=0:
    - cnt>0: asm moves to out_data with out_keep = (1<<cnt)-1, then cnt=0 and flush_pend=0.
    - cnt==0: flush_pend clears with no output.
  - Full words always carry out_keep all-ones.
  - Reset clears flush_pend and out_keep.
- Undefined: the flush and out_keep ports do not exist, and only full words are ever emitted.

Decomposition:
- Shared package fifo_pkg holds:
  - DWIDTH and PACK defaults.
  - Counter width constant CNTW = clog2(PACK+1).
  - A keep-mask function (cnt -> PACK-bit mask).
- Sub-module fifo_rd_out_reg: the OWIDTH valid/ready holding register (load, hold on stall, clear on accept). Everything else stays in the top.

Test Plan:
- Reset check: hold reset 3 cycles with empty=0 -> pop=0, out_valid=0, out_data=0 throughout; the first pop appears the cycle after reset drops.
- Streaming: DWIDTH=8, PACK=4, FIFO supplies 0x01..0x08, out_ready=1:
  - Output words are 0x04030201 then 0x08070605, consecutive pops with no gaps.
  - The first out_valid comes 2 cycles after the 4th pop.
- Backpressure: out_ready=0 after the first word completes, FIFO holds 0x11..0x18:
  - out_data stays 0x04030201.
  - Pops stop after 3 further entries (eff==PACK-1 rule).
  - Releasing out_ready produces 0x14131211 next, and nothing is lost or duplicated.
- Empty boundary: FIFO empties after 0xAA, 0xBB, 0xCC:
  - No output; pop stays 0 while empty=1.
  - Supplying 0xDD later yields 0xDDCCBBAA.
- Reset mid-word: reset pulses after 2 entries plus 1 in flight:
  - No word is emitted.
  - The next 4 entries 0x21..0x24 yield 0x24232221.
- (PACKER_FLUSH_EN) Flush: pulse flush after entries 0x55, 0x66 -> out_data[15:0]=0x6655, out_keep=4'b0011; a flush with cnt=0 produces no output.
